// File: rtl/iu_pkg.sv
// Shared key codes, operator encoding and FSM states for the calculator input unit.
package iu_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_NEG = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpMul = 2'b10,
        OpDiv = 2'b11
    } op_sel_e;

    typedef enum logic [1:0] {
        StA   = 2'b00,
        StB   = 2'b01,
        StReq = 2'b10
    } iu_state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] code);
        return (code >= KEY_ADD) && (code <= KEY_DIV);
    endfunction

    // A..D map onto add..div in order.
    function automatic op_sel_e op_from_key(input logic [3:0] code);
        return op_sel_e'(code[1:0] - 2'd2);
    endfunction

endpackage

// File: rtl/iu_digit_accum.sv
// One signed decimal operand: BCD shift register, binary accumulator, digit count and sign.
module iu_digit_accum
    import iu_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned OUT_W      = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clr,
    input  logic                                   load_digit,
    input  logic [3:0]                             digit,
    input  logic                                   toggle_sign,
    output logic [OUT_W-1:0]                       value,
    output logic [4*NUM_DIGITS-1:0]                bcd,
    output logic                                   neg,
    output logic [$clog2(NUM_DIGITS+1)-1:0]        count
);

    localparam int unsigned AccW = $clog2(10 ** NUM_DIGITS);
    localparam int unsigned BcdW = 4 * NUM_DIGITS;
    localparam int unsigned CntW = $clog2(NUM_DIGITS + 1);

    logic [AccW-1:0]  acc_q;
    logic [BcdW-1:0]  bcd_q;
    logic [CntW-1:0]  count_q;
    logic             neg_q;
    logic             accept;
    logic [OUT_W-1:0] mag;

    assign accept = load_digit && (count_q < CntW'(NUM_DIGITS));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q   <= '0;
            bcd_q   <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            if (accept) begin
                // The digit limit keeps acc*10+d below 10^NUM_DIGITS, so no wrap.
                acc_q   <= acc_q * AccW'(10) + AccW'(digit);
                bcd_q   <= (bcd_q << 4) | BcdW'(digit);
                count_q <= count_q + CntW'(1);
            end
            if (toggle_sign) begin
                neg_q <= ~neg_q;
            end
        end
    end

    assign mag   = OUT_W'(acc_q);
    assign value = neg_q ? (~mag + OUT_W'(1)) : mag;
    assign bcd   = bcd_q;
    assign neg   = neg_q;
    assign count = count_q;

endmodule

// File: rtl/iu_entry_seq.sv
// Calculator input unit: keypad events -> (A, op, B) request over valid/ready, plus entry display.
module iu_entry_seq
    import iu_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned OUT_W      = 16
) (
    input  logic                      Clock,
    input  logic                      Clear,
    input  logic                      key_valid,
    input  logic [3:0]                key_code,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [OUT_W-1:0]          op_a,
    output logic [OUT_W-1:0]          op_b,
    output logic [1:0]                op_sel,
    output logic [4*NUM_DIGITS-1:0]   disp_bcd,
    output logic                      disp_neg,
    output logic                      entry_b
);

    localparam int unsigned CntW = $clog2(NUM_DIGITS + 1);

    iu_state_e state_q;
    op_sel_e   op_sel_q;
    logic      req_valid_q;

    logic                    key_in_a, key_in_b, handshake;
    logic [4*NUM_DIGITS-1:0] bcd_a, bcd_b;
    logic                    neg_a, neg_b;
    logic [CntW-1:0]         count_a, count_b;

    assign key_in_a  = key_valid && (state_q == StA);
    assign key_in_b  = key_valid && (state_q == StB);
    assign handshake = req_valid_q && req_ready;

    iu_digit_accum #(
        .NUM_DIGITS (NUM_DIGITS),
        .OUT_W      (OUT_W)
    ) u_accum_a (
        .clk         (Clock),
        .rst         (Clear),
        .clr         (handshake),
        .load_digit  (key_in_a && is_digit(key_code)),
        .digit       (key_code),
        .toggle_sign (key_in_a && (key_code == KEY_NEG)),
        .value       (op_a),
        .bcd         (bcd_a),
        .neg         (neg_a),
        .count       (count_a)
    );

    iu_digit_accum #(
        .NUM_DIGITS (NUM_DIGITS),
        .OUT_W      (OUT_W)
    ) u_accum_b (
        .clk         (Clock),
        .rst         (Clear),
        .clr         (handshake),
        .load_digit  (key_in_b && is_digit(key_code)),
        .digit       (key_code),
        .toggle_sign (key_in_b && (key_code == KEY_NEG)),
        .value       (op_b),
        .bcd         (bcd_b),
        .neg         (neg_b),
        .count       (count_b)
    );

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q     <= StA;
            op_sel_q    <= OpAdd;
            req_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StA: begin
                    if (key_valid && is_op(key_code)) begin
                        op_sel_q <= op_from_key(key_code);
                        state_q  <= StB;
                    end
                end
                StB: begin
                    // The operator may be corrected only until B has digits.
                    if (key_valid && is_op(key_code) && (count_b == '0)) begin
                        op_sel_q <= op_from_key(key_code);
                    end else if (key_valid && (key_code == KEY_EQ)) begin
                        state_q     <= StReq;
                        req_valid_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (handshake) begin
                        state_q     <= StA;
                        op_sel_q    <= OpAdd;
                        req_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StA;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_valid = req_valid_q;
    assign op_sel    = op_sel_q;
    assign entry_b   = (state_q != StA);
    assign disp_bcd  = entry_b ? bcd_b : bcd_a;
    assign disp_neg  = entry_b ? neg_b : neg_a;

endmodule

// File: tb/tb_iu_entry_seq.sv
// Directed bench for iu_entry_seq: keypad sequences against hand-computed operands and display.
module tb_iu_entry_seq;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [15:0] op_a, op_b;
    logic [1:0]  op_sel;
    logic [15:0] disp_bcd;
    logic        disp_neg;
    logic        entry_b;

    int n_checks = 0;
    int n_fail   = 0;

    iu_entry_seq #(
        .NUM_DIGITS (4),
        .OUT_W      (16)
    ) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .key_valid (key_valid),
        .key_code  (key_code),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .disp_bcd  (disp_bcd),
        .disp_neg  (disp_neg),
        .entry_b   (entry_b)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one key for one cycle; returns on the falling edge after it was registered.
    task automatic press(input logic [3:0] code);
        @(negedge Clock);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge Clock);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic press_seq(input logic [3:0] codes[$]);
        foreach (codes[i]) press(codes[i]);
    endtask

    // Accept the outstanding request within a bounded number of cycles.
    task automatic handshake(input string tag);
        int budget = 10;
        while (!req_valid && budget > 0) begin
            @(negedge Clock);
            budget--;
        end
        check_eq({tag, "_req_seen"}, 32'(req_valid), 32'd1);
        req_ready = 1'b1;
        @(negedge Clock);
        req_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, 32'(req_valid), 32'd0);
        check_eq({tag, "_entry_b_clr"}, 32'(entry_b), 32'd0);
        check_eq({tag, "_op_a_clr"}, 32'(op_a), 32'd0);
        check_eq({tag, "_op_b_clr"}, 32'(op_b), 32'd0);
        check_eq({tag, "_disp_clr"}, 32'(disp_bcd), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge Clock);
        Clear = 1'b0;
        check_eq("rst_req_valid", 32'(req_valid), 32'd0);
        check_eq("rst_op_a", 32'(op_a), 32'd0);
        check_eq("rst_op_b", 32'(op_b), 32'd0);
        check_eq("rst_op_sel", 32'(op_sel), 32'd0);
        check_eq("rst_disp_bcd", 32'(disp_bcd), 32'd0);
        check_eq("rst_disp_neg", 32'(disp_neg), 32'd0);
        check_eq("rst_entry_b", 32'(entry_b), 32'd0);

        // 12 + 34, held off for 5 cycles
        press_seq('{4'h1, 4'h2});
        check_eq("t1_disp_a", 32'(disp_bcd), 32'h0012);
        req_ready = 1'b1;               // no effect without a request
        @(negedge Clock);
        req_ready = 1'b0;
        check_eq("t1_ready_idle", 32'(disp_bcd), 32'h0012);
        press(4'hA);
        check_eq("t1_entry_b", 32'(entry_b), 32'd1);
        check_eq("t1_disp_b_empty", 32'(disp_bcd), 32'h0000);
        press_seq('{4'h3, 4'h4});
        check_eq("t1_disp_b", 32'(disp_bcd), 32'h0034);
        press(4'hF);
        for (int i = 0; i < 5; i++) begin
            check_eq("t1_hold_valid", 32'(req_valid), 32'd1);
            @(negedge Clock);
        end
        check_eq("t1_op_a", 32'(op_a), 32'd12);
        check_eq("t1_op_b", 32'(op_b), 32'd34);
        check_eq("t1_op_sel", 32'(op_sel), 32'd0);
        check_eq("t1_disp_req", 32'(disp_bcd), 32'h0034);
        handshake("t1");

        // -5 * -7
        press_seq('{4'h5, 4'hE});
        check_eq("t2_neg_a", 32'(disp_neg), 32'd1);
        press_seq('{4'hC, 4'h7, 4'hE, 4'hF});
        check_eq("t2_op_a", 32'(op_a), 32'hFFFB);
        check_eq("t2_op_b", 32'(op_b), 32'hFFF9);
        check_eq("t2_op_sel", 32'(op_sel), 32'd2);
        check_eq("t2_disp_neg_b", 32'(disp_neg), 32'd1);
        handshake("t2");

        // Digit limit: fifth 9 ignored
        press_seq('{4'h9, 4'h9, 4'h9, 4'h9, 4'h9});
        check_eq("t3_disp_full", 32'(disp_bcd), 32'h9999);
        check_eq("t3_op_a_full", 32'(op_a), 32'd9999);
        press_seq('{4'hD, 4'h2, 4'hF});
        check_eq("t3_op_a", 32'(op_a), 32'd9999);
        check_eq("t3_op_b", 32'(op_b), 32'd2);
        check_eq("t3_op_sel", 32'(op_sel), 32'd3);
        handshake("t3");

        // Operator replaced while B empty, frozen after a B digit
        press_seq('{4'h8, 4'hA, 4'hB, 4'h3, 4'hC, 4'hF});
        check_eq("t4_op_a", 32'(op_a), 32'd8);
        check_eq("t4_op_b", 32'(op_b), 32'd3);
        check_eq("t4_op_sel", 32'(op_sel), 32'd1);
        handshake("t4");

        // Empty B, key dropped during request
        press_seq('{4'h4, 4'hA, 4'hF});
        press(4'h6);
        check_eq("t5_op_b_empty", 32'(op_b), 32'd0);
        check_eq("t5_disp_drop", 32'(disp_bcd), 32'd0);
        check_eq("t5_op_a", 32'(op_a), 32'd4);
        check_eq("t5_still_valid", 32'(req_valid), 32'd1);
        handshake("t5");
        press(4'hE);
        check_eq("t5_neg_once", 32'(disp_neg), 32'd1);
        check_eq("t5_negzero", 32'(op_a), 32'd0);
        press(4'hE);
        check_eq("t5_neg_twice", 32'(disp_neg), 32'd0);
        check_eq("t5_op_a_zero", 32'(op_a), 32'd0);

        // Clear aborts a pending request
        press_seq('{4'h7, 4'hC, 4'h1, 4'hF});
        check_eq("t6_valid", 32'(req_valid), 32'd1);
        check_eq("t6_op_sel", 32'(op_sel), 32'd2);
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        check_eq("t6_valid_clr", 32'(req_valid), 32'd0);
        check_eq("t6_entry_b", 32'(entry_b), 32'd0);
        check_eq("t6_op_a", 32'(op_a), 32'd0);
        check_eq("t6_op_b", 32'(op_b), 32'd0);
        check_eq("t6_op_sel_clr", 32'(op_sel), 32'd0);
        check_eq("t6_disp", 32'(disp_bcd), 32'd0);
        check_eq("t6_disp_neg", 32'(disp_neg), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
